// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache
//
// Purpose:
//   Answers the datapath instruction port. Hits are served combinationally
//   from register storage. A miss latches the word address and runs a
//   one-word fill from the memory controller. While the fill is running the
//   cache ignores further address changes. When the fill finishes the frame
//   is written and the cache returns to lookup.
//
// Parameters:
//   SETS        number of frames (power of 2, >= 2)
//
// Ports:
//   CLK         in   1   clock, rising edge
//   nRST        in   1   asynchronous active-low reset
//   imemREN     in   1   datapath instruction read request
//   imemaddr    in   32  instruction byte address ([1:0] ignored)
//   halt        in   1   datapath halted: suppresses hits and new fills
//   ihit        out  1   imemload holds the requested word this cycle
//   imemload    out  32  instruction word (0 when not hitting)
//   iREN        out  1   memory read request, high for the whole fill
//   iaddr       out  32  fill word address (0 outside a fill)
//   iwait       in   1   memory busy; iload is valid when iwait==0
//   iload       in   32  memory read data
//   hit_count   out  32  completed hits          (ICACHE_STATS_EN only)
//   miss_count  out  32  fills started           (ICACHE_STATS_EN only)
//
// Configuration macro:
//   ICACHE_STATS_EN -- adds the hit/miss counters and their ports.
// ---------------------------------------------------------------------------
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Frame storage: the valid bits are reset.
  // The tag and data arrays are only meaningful while the valid bit is set.
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];

  logic [31:0]        r_fill_addr;

  logic [TAG_W-1:0]   w_req_tag;
  logic [IDX_W-1:0]   w_req_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic               w_lookup_hit;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill_done;
  logic               w_unused;

  assign w_req_tag  = imemaddr[31:IDX_W+2];
  assign w_req_idx  = imemaddr[IDX_W+1:2];
  assign w_fill_tag = r_fill_addr[31:IDX_W+2];
  assign w_fill_idx = r_fill_addr[IDX_W+1:2];

  // Byte offset within the word has no effect on a word-wide cache.
  assign w_unused = ^imemaddr[1:0];

  assign w_lookup_hit = imemREN & r_valid[w_req_idx] &
                        (r_tag[w_req_idx] == w_req_tag);

  // halt masks both the hit and the miss.
  // A halted datapath therefore never sees a hit and never starts a fill.
  assign w_hit       = (r_state == IDLE) & w_lookup_hit & ~halt;
  assign w_miss      = (r_state == IDLE) & imemREN & ~w_lookup_hit & ~halt;
  assign w_fill_done = (r_state == FILL) & ~iwait;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_miss)      w_state_next = FILL;
      FILL:    if (w_fill_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    case (r_state)
      IDLE: begin
        ihit     = w_hit;
        imemload = w_hit ? r_data[w_req_idx] : 32'h0;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = r_fill_addr;
      end
      default: ;
    endcase
  end

  // The fill address is captured when the miss is detected.
  // The fill uses this held copy, so branches and jumps in the datapath
  // cannot change the fill address mid-fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fill_addr <= 32'h0;
    end else if (w_miss) begin
      r_fill_addr <= {imemaddr[31:2], 2'b00};
    end
  end

  // If the fill is aborted by reset, the valid bit is never set.
  // The half-written line is therefore never visible.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (w_fill_done) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill_done && nRST) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else if (!halt) begin
      if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- directed bench for icache (SETS = 16)
//
// Expected instruction words are queued when the bench drives a request.
// A queued word is popped and compared when the cache raises ihit.
// Control outputs (ihit/iREN/iaddr) are checked at fixed points of each step.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .halt       (halt),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Hit cycle: pop the oldest expected word and compare it to imemload.
  task automatic take_hit(input string tag);
    logic [31:0] exp_w;
    chk({tag, "_ihit"}, {31'h0, ihit}, 32'h1);
    chk({tag, "_iREN"}, {31'h0, iREN}, 32'h0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0 + sb_q.size());
    end else begin
      exp_w = sb_q.pop_front();
      chk({tag, "_data"}, imemload, exp_w);
    end
    $display("hit  addr=%h data=%h", imemaddr, imemload);
  endtask

  // One fetch transaction.
  // The task starts mid-cycle and returns mid-way through the hit cycle,
  // without advancing past it.
  task automatic fetch(input logic [31:0] a, input bit exp_hit,
                       input logic [31:0] d, input int waits);
    int lat;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    sb_q.push_back(d);
    #1;
    if (exp_hit) begin
      take_hit("fetch_hit");
    end else begin
      chk("miss_ihit", {31'h0, ihit}, 32'h0);
      chk("miss_iREN_idle", {31'h0, iREN}, 32'h0);
      step();
      chk("fill_iREN", {31'h0, iREN}, 32'h1);
      chk("fill_iaddr", iaddr, a & 32'hFFFF_FFFC);
      chk("fill_ihit", {31'h0, ihit}, 32'h0);
      chk("fill_imemload", imemload, 32'h0);
      for (int k = 0; k < waits; k++) begin
        step();
        chk("fill_wait_iREN", {31'h0, iREN}, 32'h1);
      end
      iwait = 1'b0;
      iload = d;
      step();
      iwait = 1'b1;
      iload = 32'h0;
      #1;
      lat = 0;
      while (ihit !== 1'b1 && lat < 4) begin
        step();
        lat++;
      end
      chk("fill_hit_latency", lat, 32'd0);
      take_hit("fill");
      $display("fill addr=%h data=%h waits=%0d", a, d, waits);
    end
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    halt     = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;

    // Reset state: a request during reset must not hit or start a fill.
    repeat (2) @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    imemREN = 1'b0;
    nRST    = 1'b1;
    step();

    // Scenario 1: cold miss at 0x40 with 3 busy memory cycles.
    fetch(32'h40, 1'b0, 32'h2001_0005, 3);
    step();
    // Scenario 2: miss on the neighbouring frame (idx 1).
    fetch(32'h44, 1'b0, 32'h3C01_0044, 1);
`ifdef ICACHE_STATS_EN
    chk("stats_hit_count", hit_count, 32'd1);
    chk("stats_miss_count", miss_count, 32'd2);
`endif
    step();

    // Halt: a cached address gives no hit, and an uncached one starts no fill.
    halt     = 1'b1;
    imemaddr = 32'h44;
    #1;
    chk("halt_ihit", {31'h0, ihit}, 32'h0);
    imemaddr = 32'h300;
    step();
    chk("halt_no_fill", {31'h0, iREN}, 32'h0);
    step();
    chk("halt_no_fill2", {31'h0, iREN}, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("halt_hit_count", hit_count, 32'd2);
    chk("halt_miss_count", miss_count, 32'd2);
`endif
    $display("halt addr=%h iREN=%b", imemaddr, iREN);
    imemREN = 1'b0;
    halt    = 1'b0;
    #1;

    // Scenario 3: conflict on idx 0 evicts 0x40, and frame 1 is untouched.
    fetch(32'h80, 1'b0, 32'h0000_0080, 0);
    step();
    fetch(32'h40, 1'b0, 32'h2001_0005, 2);
    step();
    fetch(32'h44, 1'b1, 32'h3C01_0044, 0);
    step();

    // Scenario 4: redirect during the fill of 0x100.
    imemaddr = 32'h100;
    sb_q.push_back(32'hAAAA_0100);
    #1;
    chk("redir_miss", {31'h0, ihit}, 32'h0);
    step();
    chk("redir_iaddr0", iaddr, 32'h100);
    imemaddr = 32'h200;
    step();
    chk("redir_iaddr_held", iaddr, 32'h100);
    iwait = 1'b0;
    iload = 32'hAAAA_0100;
    step();
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    chk("redir_new_addr_miss", {31'h0, ihit}, 32'h0);
    imemaddr = 32'h100;
    #1;
    take_hit("redir_filled_line");
    imemaddr = 32'h200;
    #1;
    sb_q.push_back(32'hBBBB_0200);
    step();
    chk("redir_second_fill_iaddr", iaddr, 32'h200);
    iwait = 1'b0;
    iload = 32'hBBBB_0200;
    step();
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    take_hit("redir_second");
    step();

    // Scenario 5: reset pulse mid-fill aborts it and invalidates all frames.
    imemaddr = 32'h40;
    #1;
    chk("abort_pre_miss", {31'h0, ihit}, 32'h0);
    step();
    chk("abort_fill_iREN", {31'h0, iREN}, 32'h1);
    #1;
    nRST = 1'b0;
    #1;
    chk("abort_iREN", {31'h0, iREN}, 32'h0);
    chk("abort_iaddr", iaddr, 32'h0);
    sb_q.delete();
    #1;
    nRST = 1'b1;
    #1;
    imemaddr = 32'h44;
    #1;
    chk("abort_frame1_invalid", {31'h0, ihit}, 32'h0);
    imemREN = 1'b0;
    #1;
    step();
    fetch(32'h40, 1'b0, 32'h1234_5678, 2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
